axi_dma_cmd_arbiter: RTL and testbench

//   Upstream command front-end for axi_dma_controller. Collects DMA commands from CHANNEL_COUNT

---
 rtl/axi_dma_cmd_arbiter.sv | 157 +++++++++++++++
 tb/tb_axi_dma_cmd_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dma_cmd_arbiter.sv
// Round-robin command arbiter and FIFO in front of axi_dma_controller.
// Define AXI_DMA_CMD_CHECK_EN to drop illegal commands and report them on err_*.
module axi_dma_cmd_arbiter #(
    parameter int ADDR_WD       = 32,
    parameter int DATA_WD       = 32,
    parameter int LEN_WD        = 32,
    parameter int CHANNEL_COUNT = 8,
    parameter int FIFO_DEPTH    = 4,
    localparam int CW           = $clog2(CHANNEL_COUNT),
    localparam int NW           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CHANNEL_COUNT-1:0]           in_valid,
    input  logic [CHANNEL_COUNT*ADDR_WD-1:0]   in_src_addr,
    input  logic [CHANNEL_COUNT*ADDR_WD-1:0]   in_dst_addr,
    input  logic [CHANNEL_COUNT*2-1:0]         in_burst,
    input  logic [CHANNEL_COUNT*LEN_WD-1:0]    in_len,
    input  logic [CHANNEL_COUNT*3-1:0]         in_size,
    output logic [CHANNEL_COUNT-1:0]           in_ready,
    output logic                               cmd_valid,
    output logic [ADDR_WD-1:0]                 cmd_src_addr,
    output logic [ADDR_WD-1:0]                 cmd_dst_addr,
    output logic [1:0]                         cmd_burst,
    output logic [LEN_WD-1:0]                  cmd_len,
    output logic [2:0]                         cmd_size,
    output logic [CW-1:0]                      cmd_chan,
    input  logic                               cmd_ready,
    output logic [NW-1:0]                      fifo_count,
    output logic                               err_valid,
    output logic [CW-1:0]                      err_chan
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(CHANNEL_COUNT - 1);

    logic [ADDR_WD-1:0] mem_src   [FIFO_DEPTH];
    logic [ADDR_WD-1:0] mem_dst   [FIFO_DEPTH];
    logic [1:0]         mem_burst [FIFO_DEPTH];
    logic [LEN_WD-1:0]  mem_len   [FIFO_DEPTH];
    logic [2:0]         mem_size  [FIFO_DEPTH];
    logic [CW-1:0]      mem_chan  [FIFO_DEPTH];

    logic [AW-1:0]            rd_ptr;
    logic [AW-1:0]            wr_ptr;
    logic [NW-1:0]            count;
    logic [CW-1:0]            rr;
    logic [CHANNEL_COUNT-1:0] illegal;
    logic [CHANNEL_COUNT-1:0] eligible;
    logic [CHANNEL_COUNT-1:0] grant;
    logic [CW-1:0]            gidx;
    logic                     found;
    logic                     space;
    logic                     push;
    logic                     pop;

    assign cmd_valid    = (count != '0);
    assign fifo_count   = count;
    assign pop          = cmd_valid & cmd_ready;
    assign space        = (count < FULL) | pop;
    assign cmd_src_addr = mem_src[rd_ptr];
    assign cmd_dst_addr = mem_dst[rd_ptr];
    assign cmd_burst    = mem_burst[rd_ptr];
    assign cmd_len      = mem_len[rd_ptr];
    assign cmd_size     = mem_size[rd_ptr];
    assign cmd_chan     = mem_chan[rd_ptr];

`ifdef AXI_DMA_CMD_CHECK_EN
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WD / 8));

    always_comb begin
        illegal = '0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            illegal[i] = (in_len[i*LEN_WD +: LEN_WD] == '0)
                | (in_burst[i*2 +: 2] == 2'b11)
                | (in_size[i*3 +: 3] > MAX_SIZE)
                | (|(in_src_addr[i*ADDR_WD +: ADDR_WD]
                     & ((ADDR_WD'(1) << in_size[i*3 +: 3]) - ADDR_WD'(1))))
                | (|(in_dst_addr[i*ADDR_WD +: ADDR_WD]
                     & ((ADDR_WD'(1) << in_size[i*3 +: 3]) - ADDR_WD'(1))))
                | (|(in_len[i*LEN_WD +: LEN_WD]
                     & ((LEN_WD'(1) << in_size[i*3 +: 3]) - LEN_WD'(1))));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_valid <= 1'b0;
            err_chan  <= '0;
        end else begin
            err_valid <= found & illegal[gidx];
            if (found & illegal[gidx])
                err_chan <= gidx;
        end
    end
`else
    assign illegal   = '0;
    assign err_valid = 1'b0;
    assign err_chan  = '0;
`endif

    // Dropped commands never occupy the FIFO, so they may win even when full.
    assign eligible = rst ? (in_valid & (space ? '1 : illegal)) : '0;

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int j = 0; j < CHANNEL_COUNT; j++) begin
            int idx;
            idx = int'(rr) + j;
            if (idx >= CHANNEL_COUNT)
                idx = idx - CHANNEL_COUNT;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                gidx  = CW'(idx);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found)
            grant[gidx] = 1'b1;
    end

    assign in_ready = grant;
    assign push     = found & ~illegal[gidx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rr     <= '0;
        end else begin
            if (push) begin
                mem_src[wr_ptr]   <= in_src_addr[gidx*ADDR_WD +: ADDR_WD];
                mem_dst[wr_ptr]   <= in_dst_addr[gidx*ADDR_WD +: ADDR_WD];
                mem_burst[wr_ptr] <= in_burst[gidx*2 +: 2];
                mem_len[wr_ptr]   <= in_len[gidx*LEN_WD +: LEN_WD];
                mem_size[wr_ptr]  <= in_size[gidx*3 +: 3];
                mem_chan[wr_ptr]  <= gidx;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
            if (found)
                rr <= (gidx == LAST) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_dma_cmd_arbiter.sv
// Directed vector bench for axi_dma_cmd_arbiter (8 channels, 4-entry FIFO).
// Also covers illegal-command handling when AXI_DMA_CMD_CHECK_EN is defined.
module tb_axi_dma_cmd_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_valid;
    logic [255:0] in_src_addr;
    logic [255:0] in_dst_addr;
    logic [15:0]  in_burst;
    logic [255:0] in_len;
    logic [23:0]  in_size;
    logic [7:0]   in_ready;
    logic         cmd_valid;
    logic [31:0]  cmd_src_addr;
    logic [31:0]  cmd_dst_addr;
    logic [1:0]   cmd_burst;
    logic [31:0]  cmd_len;
    logic [2:0]   cmd_size;
    logic [2:0]   cmd_chan;
    logic         cmd_ready;
    logic [2:0]   fifo_count;
    logic         err_valid;
    logic [2:0]   err_chan;

    logic [31:0] src [8];
    logic [31:0] dst [8];
    logic [31:0] len [8];
    logic [2:0]  size [8];
    logic [1:0]  burst [8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            in_src_addr[i*32 +: 32] = src[i];
            in_dst_addr[i*32 +: 32] = dst[i];
            in_len[i*32 +: 32]      = len[i];
            in_size[i*3 +: 3]       = size[i];
            in_burst[i*2 +: 2]      = burst[i];
        end
    end

    axi_dma_cmd_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_src_addr  (in_src_addr),
        .in_dst_addr  (in_dst_addr),
        .in_burst     (in_burst),
        .in_len       (in_len),
        .in_size      (in_size),
        .in_ready     (in_ready),
        .cmd_valid    (cmd_valid),
        .cmd_src_addr (cmd_src_addr),
        .cmd_dst_addr (cmd_dst_addr),
        .cmd_burst    (cmd_burst),
        .cmd_len      (cmd_len),
        .cmd_size     (cmd_size),
        .cmd_chan     (cmd_chan),
        .cmd_ready    (cmd_ready),
        .fifo_count   (fifo_count),
        .err_valid    (err_valid),
        .err_chan     (err_chan)
    );

    typedef struct {
        logic       rst;
        logic [7:0] valid;
        logic       rdy;
        logic [7:0] exp_ready;
        logic       exp_cv;
        logic [2:0] exp_cnt;
        logic [2:0] exp_chan;
    } vec_t;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [2:0]  chan;
    } cmd_t;

    vec_t vecs [29];
    cmd_t q [$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic head_fields(input string tag, input int ch);
        chk({tag, "_src"}, 64'(cmd_src_addr), 64'(src[ch]));
        chk({tag, "_dst"}, 64'(cmd_dst_addr), 64'(dst[ch]));
        chk({tag, "_len"}, 64'(cmd_len), 64'(len[ch]));
        chk({tag, "_size"}, 64'(cmd_size), 64'(size[ch]));
        chk({tag, "_burst"}, 64'(cmd_burst), 64'(burst[ch]));
    endtask

    task automatic illegal_case(input string tag, input int ch);
        in_valid  = 8'h01 << ch;
        cmd_ready = 1'b1;
        #1;
        chk({tag, "_grant"}, 64'(in_ready), 64'(8'h01 << ch));
        tick();
        in_valid = 8'h00;
        #1;
`ifdef AXI_DMA_CMD_CHECK_EN
        chk({tag, "_err"}, 64'(err_valid), 64'd1);
        chk({tag, "_err_chan"}, 64'(err_chan), 64'(ch));
        chk({tag, "_cnt"}, 64'(fifo_count), 64'd0);
        chk({tag, "_cv"}, 64'(cmd_valid), 64'd0);
`else
        chk({tag, "_err"}, 64'(err_valid), 64'd0);
        chk({tag, "_cnt"}, 64'(fifo_count), 64'd1);
        chk({tag, "_chan"}, 64'(cmd_chan), 64'(ch));
        head_fields(tag, ch);
`endif
        tick();
        #1;
        chk({tag, "_err_end"}, 64'(err_valid), 64'd0);
        chk({tag, "_cnt_end"}, 64'(fifo_count), 64'd0);
    endtask

    initial begin
        int pushed;
        int popped;
        int cyc;
        int gch;
        cmd_t c;

        for (int i = 0; i < 8; i++) begin
            src[i]   = 32'h1000 + 32'(i) * 32'h40;
            dst[i]   = 32'h2000 + 32'(i) * 32'h40;
            len[i]   = 32'd64;
            size[i]  = 3'd2;
            burst[i] = 2'd1;
        end
        src[3] = 32'h100;
        dst[3] = 32'h200;

        // rst, valid, rdy, in_ready, cmd_valid, count, chan
        vecs[0]  = '{1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0};
        vecs[1]  = '{1'b1, 8'h08, 1'b1, 8'h08, 1'b0, 3'd0, 3'd0};
        vecs[2]  = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 3'd1, 3'd3};
        vecs[3]  = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0};
        vecs[5]  = '{1'b1, 8'hFF, 1'b1, 8'h01, 1'b0, 3'd0, 3'd0};
        vecs[6]  = '{1'b1, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, 3'd0};
        vecs[7]  = '{1'b1, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd1, 3'd1};
        vecs[8]  = '{1'b1, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd1, 3'd2};
        vecs[9]  = '{1'b1, 8'hFF, 1'b1, 8'h10, 1'b1, 3'd1, 3'd3};
        vecs[10] = '{1'b1, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd1, 3'd4};
        vecs[11] = '{1'b1, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd1, 3'd5};
        vecs[12] = '{1'b1, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd1, 3'd6};
        vecs[13] = '{1'b1, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd1, 3'd7};
        vecs[14] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 3'd1, 3'd0};
        vecs[15] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0};
        vecs[16] = '{1'b1, 8'h3F, 1'b0, 8'h02, 1'b0, 3'd0, 3'd0};
        vecs[17] = '{1'b1, 8'h3F, 1'b0, 8'h04, 1'b1, 3'd1, 3'd1};
        vecs[18] = '{1'b1, 8'h3F, 1'b0, 8'h08, 1'b1, 3'd2, 3'd1};
        vecs[19] = '{1'b1, 8'h3F, 1'b0, 8'h10, 1'b1, 3'd3, 3'd1};
        vecs[20] = '{1'b1, 8'h3F, 1'b0, 8'h00, 1'b1, 3'd4, 3'd1};
        vecs[21] = '{1'b1, 8'h3F, 1'b1, 8'h20, 1'b1, 3'd4, 3'd1};
        vecs[22] = '{1'b1, 8'h3F, 1'b0, 8'h00, 1'b1, 3'd4, 3'd2};
        vecs[23] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 3'd4, 3'd2};
        vecs[24] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 3'd3, 3'd3};
        vecs[25] = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3, 3'd3};
        vecs[26] = '{1'b1, 8'hFF, 1'b0, 8'h01, 1'b0, 3'd0, 3'd0};
        vecs[27] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 3'd1, 3'd0};
        vecs[28] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0};

        rst       = 1'b0;
        in_valid  = 8'h00;
        cmd_ready = 1'b0;
        tick();
        tick();

        for (int v = 0; v < 29; v++) begin
            rst       = vecs[v].rst;
            in_valid  = vecs[v].valid;
            cmd_ready = vecs[v].rdy;
            #1;
            chk($sformatf("v%0d_in_ready", v), 64'(in_ready),
                64'(vecs[v].exp_ready));
            chk($sformatf("v%0d_cmd_valid", v), 64'(cmd_valid),
                64'(vecs[v].exp_cv));
            chk($sformatf("v%0d_count", v), 64'(fifo_count),
                64'(vecs[v].exp_cnt));
            chk($sformatf("v%0d_err", v), 64'(err_valid), 64'd0);
            if (vecs[v].exp_cv) begin
                chk($sformatf("v%0d_chan", v), 64'(cmd_chan),
                    64'(vecs[v].exp_chan));
                head_fields($sformatf("v%0d", v), int'(vecs[v].exp_chan));
            end
            tick();
        end
        rst = 1'b1;

        len[5] = 32'd0;
        illegal_case("bad_len_ch5", 5);
        len[5] = 32'd64;

        size[2] = 3'd1;
        src[2]  = 32'h3;
        illegal_case("bad_align_ch2", 2);
        size[2] = 3'd2;
        src[2]  = 32'h1080;

        pushed = 0;
        popped = 0;
        cyc    = 0;
        while ((pushed < 10 || popped < 10) && cyc < 300) begin
            in_valid  = (pushed < 10) ? 8'hFF : 8'h00;
            cmd_ready = 1'($urandom_range(0, 1));
            #1;
            if (cmd_valid && cmd_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wrap_extra_pop actual=1 required=0");
                end else begin
                    c = q.pop_front();
                    chk("wrap_src", 64'(cmd_src_addr), 64'(c.src));
                    chk("wrap_dst", 64'(cmd_dst_addr), 64'(c.dst));
                    chk("wrap_len", 64'(cmd_len), 64'(c.len));
                    chk("wrap_burst", 64'(cmd_burst), 64'(c.burst));
                    chk("wrap_size", 64'(cmd_size), 64'(c.size));
                    chk("wrap_chan", 64'(cmd_chan), 64'(c.chan));
                end
                popped++;
            end
            gch = -1;
            for (int i = 0; i < 8; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    q.push_back('{src[i], dst[i], len[i], burst[i],
                                  size[i], 3'(i)});
                    pushed++;
                    gch = i;
                end
            end
            tick();
            if (gch >= 0) begin
                src[gch]   = $urandom & 32'hFFFF_FFFC;
                dst[gch]   = $urandom & 32'hFFFF_FFFC;
                len[gch]   = 32'($urandom_range(1, 1024)) << 2;
                burst[gch] = 2'($urandom_range(0, 2));
            end
            cyc++;
        end
        chk("wrap_pushed", 64'(pushed), 64'd10);
        chk("wrap_popped", 64'(popped), 64'd10);
        chk("wrap_left", 64'(q.size()), 64'd0);
        in_valid  = 8'h00;
        cmd_ready = 1'b0;
        #1;
        chk("wrap_empty", 64'(fifo_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
